// File: rtl/spi_stream_pkg.sv
// Shared definitions for the SPI byte-stream controller: register offsets on
// both the CPU side and the SPI peripheral side, STATUS/CTRL bit positions and
// the engine state encoding.
package spi_stream_pkg;

    // CPU-facing register map (byte addresses, decoded on bits [11:2])
    localparam logic [11:0] CPU_DATA_ADDR   = 12'h000;
    localparam logic [11:0] CPU_STATUS_ADDR = 12'h004;
    localparam logic [11:0] CPU_CTRL_ADDR   = 12'h008;

    // SPI peripheral register map driven by the engine
    localparam logic [11:0] SPI_DATA_ADDR   = 12'h000;
    localparam logic [11:0] SPI_STATUS_ADDR = 12'h004;
    localparam logic [11:0] SPI_CTRL_ADDR   = 12'h008;

    // tx_done flag position inside the SPI peripheral status word
    localparam int SPI_TX_DONE_BIT = 1;

    // STATUS bit positions
    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_BUSY     = 4;
    localparam int ST_TXOVF    = 5;
    localparam int ST_TMO      = 6;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_FLUSH  = 3;

    // Engine states
    typedef enum logic [2:0] {
        ENG_IDLE  = 3'd0,
        ENG_LOAD  = 3'd1,
        ENG_START = 3'd2,
        ENG_WAIT  = 3'd3,
        ENG_READ  = 3'd4
    } engState_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with push/pop/flush, full/empty/count and a registered head.
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo
    import spi_stream_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [7:0]               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic [AW-1:0] wrIdx;
    logic          pushOk;
    logic          popOk;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;

    // Next pointer/count/head; a flush restarts at slot 0 but still accepts a same-cycle push
    always_comb begin
        pushOk  = push_i && (!full_o || flush_i);
        popOk   = pop_i && !empty_o && !flush_i;
        wrIdx   = flush_i ? '0 : wrPtr_q;
        rdPtr_d = flush_i ? '0 : rdPtr_q + AW'(popOk);
        wrPtr_d = wrIdx + AW'(pushOk);
        if (flush_i) begin
            count_d = (AW+1)'(pushOk);
        end else begin
            count_d = count_q + (AW+1)'(pushOk) - (AW+1)'(popOk);
        end
        if (pushOk && (wrIdx == rdPtr_d)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rdPtr_d];
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrIdx] <= data_i;
        end
    end

    // Pointer, count and head registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/spi_stream_ctrl.sv
// Memory-mapped byte-stream front end for the SPI peripheral. The CPU fills a
// TX FIFO and drains an RX FIFO; an engine walks each byte through the SPI
// register port (load data, start, poll tx_done, read back) without CPU help.
module spi_stream_ctrl
    import spi_stream_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        REN,
    input  logic        WEN,
    input  logic [11:0] Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        irq,
    output logic        m_CS,
    output logic        m_REN,
    output logic        m_WEN,
    output logic [11:0] m_Addr,
    output logic [31:0] m_DataIn,
    input  logic [31:0] m_DataOut
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    engState_e      engState_q;
    logic [WDW-1:0] wdog_q;
    logic           enable_q;
    logic           irqEn_q;
    logic           txovf_q;
    logic           tmo_q;
    logic           irq_q;

    logic           dataSel, statusSel, ctrlSel;
    logic           txPush, rxPop, ctrlWrite, flush, clearSticky;
    logic           engPop, rxPush, busy, timeoutHit, txDone;
    logic [7:0]     txHead, rxHead;
    logic           txFull, txEmpty, rxFull, rxEmpty;
    logic [CW-1:0]  txCount, rxCount;
    logic [31:0]    statusWord;
    logic           unusedBits;

    assign dataSel     = CS && (Addr[11:2] == CPU_DATA_ADDR[11:2]);
    assign statusSel   = CS && (Addr[11:2] == CPU_STATUS_ADDR[11:2]);
    assign ctrlSel     = CS && (Addr[11:2] == CPU_CTRL_ADDR[11:2]);
    assign txPush      = dataSel && WEN;
    assign rxPop       = dataSel && REN;
    assign ctrlWrite   = ctrlSel && WEN;
    assign flush       = ctrlWrite && DataIn[CTRL_FLUSH];
    assign clearSticky = ctrlWrite && DataIn[CTRL_CLEAR];

    assign engPop     = (engState_q == ENG_START);
    assign rxPush     = (engState_q == ENG_READ);
    assign busy       = (engState_q != ENG_IDLE);
    assign txDone     = m_DataOut[SPI_TX_DONE_BIT];
    assign timeoutHit = (engState_q == ENG_WAIT) && !txDone && (wdog_q == WDW'(TIMEOUT - 1));
    assign irq        = irq_q;
    assign unusedBits = ^{Addr[1:0], DataIn[31:8], m_DataOut[31:8]};

    byte_fifo #(.DEPTH(DEPTH)) u_txFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (txPush),
        .data_i  (DataIn[7:0]),
        .pop_i   (engPop),
        .flush_i (flush),
        .head_o  (txHead),
        .full_o  (txFull),
        .empty_o (txEmpty),
        .count_o (txCount)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rxFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rxPush),
        .data_i  (m_DataOut[7:0]),
        .pop_i   (rxPop),
        .flush_i (flush),
        .head_o  (rxHead),
        .full_o  (rxFull),
        .empty_o (rxEmpty),
        .count_o (rxCount)
    );

    // Engine sequencing; a full RX FIFO holds it in IDLE so RX can never overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            engState_q <= ENG_IDLE;
            wdog_q     <= '0;
        end else begin
            case (engState_q)
                ENG_IDLE: begin
                    if (enable_q && !txEmpty && !rxFull) begin
                        engState_q <= ENG_LOAD;
                    end
                end
                ENG_LOAD: begin
                    engState_q <= ENG_START;
                end
                ENG_START: begin
                    wdog_q     <= '0;
                    engState_q <= ENG_WAIT;
                end
                ENG_WAIT: begin
                    if (txDone) begin
                        engState_q <= ENG_READ;
                    end else if (timeoutHit) begin
                        engState_q <= ENG_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ENG_READ: begin
                    engState_q <= ENG_IDLE;
                end
                default: begin
                    engState_q <= ENG_IDLE;
                end
            endcase
        end
    end

    // CTRL read/write bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= 1'b0;
            irqEn_q  <= 1'b0;
        end else if (ctrlWrite) begin
            enable_q <= DataIn[CTRL_ENABLE];
            irqEn_q  <= DataIn[CTRL_IRQ_EN];
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txovf_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            if (clearSticky) begin
                txovf_q <= 1'b0;
                tmo_q   <= 1'b0;
            end
            if (txPush && txFull) begin
                txovf_q <= 1'b1;
            end
            if (timeoutHit) begin
                tmo_q <= 1'b1;
            end
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irqEn_q && ((txEmpty && !busy) || txovf_q || tmo_q);
        end
    end

    // SPI register-port strobes decoded straight from the engine state
    always_comb begin
        m_CS     = 1'b0;
        m_REN    = 1'b0;
        m_WEN    = 1'b0;
        m_Addr   = 12'h000;
        m_DataIn = 32'h0;
        case (engState_q)
            ENG_LOAD: begin
                m_CS     = 1'b1;
                m_WEN    = 1'b1;
                m_Addr   = SPI_DATA_ADDR;
                m_DataIn = {24'h0, txHead};
            end
            ENG_START: begin
                m_CS     = 1'b1;
                m_WEN    = 1'b1;
                m_Addr   = SPI_CTRL_ADDR;
                m_DataIn = 32'h1;
            end
            ENG_WAIT: begin
                m_CS   = 1'b1;
                m_REN  = 1'b1;
                m_Addr = SPI_STATUS_ADDR;
            end
            ENG_READ: begin
                m_CS   = 1'b1;
                m_REN  = 1'b1;
                m_Addr = SPI_DATA_ADDR;
            end
            default: begin
                m_CS = 1'b0;
            end
        endcase
    end

    // CPU read mux; counts are zero-extended into their byte lanes
    always_comb begin
        statusWord                 = 32'h0;
        statusWord[ST_TX_EMPTY]    = txEmpty;
        statusWord[ST_TX_FULL]     = txFull;
        statusWord[ST_RX_EMPTY]    = rxEmpty;
        statusWord[ST_RX_FULL]     = rxFull;
        statusWord[ST_BUSY]        = busy;
        statusWord[ST_TXOVF]       = txovf_q;
        statusWord[ST_TMO]         = tmo_q;
        statusWord[15:8]           = 8'(txCount);
        statusWord[23:16]          = 8'(rxCount);
        DataOut = 32'h0;
        if (CS && REN) begin
            if (dataSel) begin
                DataOut = rxEmpty ? 32'h0 : {24'h0, rxHead};
            end else if (statusSel) begin
                DataOut = statusWord;
            end else if (ctrlSel) begin
                DataOut = {30'h0, irqEn_q, enable_q};
            end
        end
    end

endmodule

// File: tb/tb_spi_stream_ctrl.sv
// Directed self-checking bench for spi_stream_ctrl with a small SPI peripheral
// model (loopback, or a hang mode that never raises tx_done).
module tb_spi_stream_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CS = 1'b0, REN = 1'b0, WEN = 1'b0;
    logic [11:0] Addr = 12'h0;
    logic [31:0] DataIn = 32'h0;
    logic [31:0] DataOut;
    logic        irq;
    logic        m_CS, m_REN, m_WEN;
    logic [11:0] m_Addr;
    logic [31:0] m_DataIn;
    logic [31:0] m_DataOut;

    int testsRun  = 0;
    int failCount = 0;

    // SPI peripheral model state
    logic       hang = 1'b0;
    logic [7:0] shiftReg, rxReg;
    logic [2:0] busyCnt;
    logic       doneQ;
    int         waitPolls = 0;

    typedef struct {
        logic        isWrite;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs [32];
    int   nVec = 0;

    spi_stream_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .CS        (CS),
        .REN       (REN),
        .WEN       (WEN),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .irq       (irq),
        .m_CS      (m_CS),
        .m_REN     (m_REN),
        .m_WEN     (m_WEN),
        .m_Addr    (m_Addr),
        .m_DataIn  (m_DataIn),
        .m_DataOut (m_DataOut)
    );

    always #5 clk = ~clk;

    // Peripheral: latch data on write to 0x000, start a 3-cycle transfer on 0x008, one-cycle tx_done
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftReg <= 8'h0;
            rxReg    <= 8'h0;
            busyCnt  <= 3'd0;
            doneQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (m_CS && m_WEN && m_Addr == 12'h000) shiftReg <= m_DataIn[7:0];
            if (m_CS && m_WEN && m_Addr == 12'h008 && m_DataIn[0]) begin
                busyCnt <= 3'd3;
            end else if (busyCnt != 3'd0) begin
                busyCnt <= busyCnt - 3'd1;
                if (busyCnt == 3'd1 && !hang) begin
                    doneQ <= 1'b1;
                    rxReg <= shiftReg;
                end
            end
        end
    end

    assign m_DataOut = (m_CS && m_REN && m_Addr == 12'h004) ? {30'h0, doneQ, 1'b0} :
                       (m_CS && m_REN && m_Addr == 12'h000) ? {24'h0, rxReg} : 32'h0;

    // Count cycles spent polling the peripheral status register
    always @(posedge clk) begin
        if (m_CS && m_REN && m_Addr == 12'h004) waitPolls <= waitPolls + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic addVec(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [31:0] e);
        vecs[nVec] = '{isWrite: w, addr: a, data: d, expRead: e};
        nVec++;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input logic [11:0] a, input logic [31:0] d);
        CS = 1'b1; WEN = 1'b1; Addr = a; DataIn = d;
        @(posedge clk);
        #1;
        CS = 1'b0; WEN = 1'b0; DataIn = 32'h0;
    endtask

    task automatic cpuRead(input logic [11:0] a, output logic [31:0] d);
        CS = 1'b1; REN = 1'b1; Addr = a;
        @(negedge clk);
        d = DataOut;
        @(posedge clk);
        #1;
        CS = 1'b0; REN = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] rd;
        if (v.isWrite) begin
            cpuWrite(v.addr, v.data);
        end else begin
            cpuRead(v.addr, rd);
            checkOutput($sformatf("vec[%0d]", idx), rd, v.expRead);
        end
    endtask

    task automatic waitStatus(input string name, input logic [31:0] mask, input logic [31:0] val, input int budget);
        logic [31:0] rd;
        bit hit = 0;
        rd = 32'h0;
        for (int i = 0; i < budget && !hit; i++) begin
            cpuRead(12'h004, rd);
            if ((rd & mask) == val) hit = 1;
        end
        testsRun++;
        if (!hit) begin
            failCount++;
            $display("[TB] FAIL %s timed out, status 0x%08h required 0x%08h under mask", name, rd, val);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          pollStart;

        // Register-access table: enable stays 0 so the engine never drains TX
        addVec(0, 12'h004, 0, 32'h0000_0005);
        addVec(0, 12'h008, 0, 32'h0);
        addVec(0, 12'h000, 0, 32'h0);
        addVec(0, 12'h00C, 0, 32'h0);
        addVec(1, 12'h00C, 32'h3, 0);
        addVec(0, 12'h008, 0, 32'h0);
        addVec(1, 12'h000, 32'h11, 0);
        addVec(0, 12'h004, 0, 32'h0000_0104);
        addVec(1, 12'h000, 32'h22, 0);
        addVec(1, 12'h000, 32'h33, 0);
        addVec(1, 12'h000, 32'h44, 0);
        addVec(0, 12'h004, 0, 32'h0000_0406);
        addVec(1, 12'h000, 32'h55, 0);
        addVec(0, 12'h004, 0, 32'h0000_0426);
        addVec(1, 12'h008, 32'h4, 0);
        addVec(0, 12'h004, 0, 32'h0000_0406);
        addVec(1, 12'h008, 32'h2, 0);
        addVec(0, 12'h008, 0, 32'h2);
        addVec(1, 12'h008, 32'hA, 0);
        addVec(0, 12'h004, 0, 32'h0000_0005);
        addVec(0, 12'h008, 0, 32'h2);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resetIrq", {31'h0, irq}, 32'h0);
        checkOutput("resetStrobes", {17'h0, m_CS, m_WEN, m_REN, m_Addr}, 32'h0);
        checkOutput("resetMData", m_DataIn, 32'h0);
        checkOutput("resetDataOut", DataOut, 32'h0);

        for (int i = 0; i < nVec; i++) applyStimulus(vecs[i], i);
        checkOutput("irqTxEmptyIdle", {31'h0, irq}, 32'h1);

        // Loopback: two bytes go out and come back in order
        cpuWrite(12'h008, 32'h1);
        cpuWrite(12'h000, 32'hA5);
        cpuWrite(12'h000, 32'h3C);
        @(negedge clk);
        checkOutput("firstLoadStrobes", {17'h0, m_CS, m_WEN, m_REN, m_Addr}, {17'h0, 3'b110, 12'h000});
        checkOutput("firstLoadData", m_DataIn, 32'hA5);
        @(posedge clk);
        #1;
        waitStatus("loopbackRx2", 32'h00FF_0000, 32'h0002_0000, 200);
        cpuRead(12'h004, rd);
        checkOutput("loopbackStatus", rd, 32'h0002_0001);
        cpuRead(12'h000, rd);
        checkOutput("loopbackByte0", rd, 32'hA5);
        cpuRead(12'h000, rd);
        checkOutput("loopbackByte1", rd, 32'h3C);
        cpuRead(12'h004, rd);
        checkOutput("loopbackDrained", rd, 32'h0000_0005);

        // RX full stalls the engine; one pop allows exactly one more transfer
        for (int i = 0; i < 4; i++) cpuWrite(12'h000, 32'h10 + i);
        waitStatus("stallRxFull", 32'h00FF_0000, 32'h0004_0000, 300);
        cpuWrite(12'h000, 32'h14);
        cpuWrite(12'h000, 32'h15);
        idleCycles(20);
        cpuRead(12'h004, rd);
        checkOutput("stallStatus", rd, 32'h0004_0208);
        cpuRead(12'h000, rd);
        checkOutput("stallPop", rd, 32'h10);
        idleCycles(30);
        cpuRead(12'h004, rd);
        checkOutput("stallOneMore", rd, 32'h0004_0108);
        cpuWrite(12'h008, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cpuRead(12'h000, rd);
            checkOutput($sformatf("stallDrain%0d", i), rd, 32'h11 + i);
        end
        cpuRead(12'h004, rd);
        checkOutput("stallLeftover", rd, 32'h0000_0104);
        cpuWrite(12'h008, 32'h8);
        cpuRead(12'h004, rd);
        checkOutput("flushStatus", rd, 32'h0000_0005);

        // Watchdog: peripheral never signals tx_done
        hang = 1'b1;
        cpuWrite(12'h008, 32'h3);
        pollStart = waitPolls;
        cpuWrite(12'h000, 32'h77);
        idleCycles(5);
        checkOutput("irqWhileBusy", {31'h0, irq}, 32'h0);
        cpuRead(12'h004, rd);
        checkOutput("busyInWait", rd & 32'h10, 32'h10);
        waitStatus("tmoSet", 32'h40, 32'h40, 300);
        idleCycles(2);
        checkOutput("waitCycles", waitPolls - pollStart, TIMEOUT);
        cpuRead(12'h004, rd);
        checkOutput("tmoStatus", rd, 32'h0000_0045);
        checkOutput("irqOnTmo", {31'h0, irq}, 32'h1);

        // Asynchronous reset in the middle of WAIT
        cpuWrite(12'h000, 32'h66);
        idleCycles(4);
        checkOutput("inWaitStrobes", {17'h0, m_CS, m_WEN, m_REN, m_Addr}, {17'h0, 3'b101, 12'h004});
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstStrobes", {17'h0, m_CS, m_WEN, m_REN, m_Addr}, 32'h0);
        checkOutput("asyncRstIrq", {31'h0, irq}, 32'h0);
        hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cpuRead(12'h004, rd);
        checkOutput("postRstStatus", rd, 32'h0000_0005);
        cpuRead(12'h008, rd);
        checkOutput("postRstCtrl", rd, 32'h0);
        cpuWrite(12'h008, 32'h1);
        cpuWrite(12'h000, 32'h99);
        waitStatus("postRstRx", 32'h00FF_0000, 32'h0001_0000, 200);
        cpuRead(12'h000, rd);
        checkOutput("postRstByte", rd, 32'h99);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/spi_stream_ctrl.md
# spi_stream_ctrl

Memory-mapped byte-stream controller that sits directly upstream of the SPI peripheral. The CPU pushes bytes into a TX FIFO and pops received bytes from an RX FIFO. An internal engine drives the SPI peripheral's register port: it loads the data register, pulses start, polls status for `tx_done`, then reads the received byte. The result is back-to-back SPI transfers without per-byte CPU polling.

## Interface
Parameters:
- `DEPTH`, default 8: entries per FIFO. Must be a power of two, 2..128.
- `TIMEOUT`, default 1023: maximum WAIT cycles before the engine aborts a byte.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `CS`, `REN`, `WEN` in 1: CPU-side select, read strobe and write strobe.
- `Addr` in 12: CPU byte address. Decoded on `Addr[11:2]`.
- `DataIn` in 32: CPU write data.
- `DataOut` out 32: CPU read data. Combinational; 0 when not `CS && REN`.
- `irq` out 1: level interrupt, registered.
- `m_CS`, `m_REN`, `m_WEN` out 1: select and strobes to the SPI peripheral.
- `m_Addr` out 12: SPI register address.
- `m_DataIn` out 32: write data to the SPI peripheral.
- `m_DataOut` in 32: read data from the SPI peripheral. Combinational on the SPI side.

## Operation
CPU register map:
- 0x00 write: push `DataIn[7:0]` into the TX FIFO. If the TX FIFO is full, the byte is dropped and sticky `TXOVF` is set.
- 0x00 read: returns `{24'b0, rx_head}`, or 0 if the RX FIFO is empty. Pops one entry on each clk edge where `CS && REN` addresses 0x00 and the FIFO is not empty.
- 0x04 read, STATUS:
  - bit 0 tx_empty, bit 1 tx_full, bit 2 rx_empty, bit 3 rx_full
  - bit 4 busy (engine not IDLE), bit 5 TXOVF, bit 6 TMO
  - bits [15:8] tx_count, bits [23:16] rx_count
- 0x08 CTRL:
  - bit 0 enable and bit 1 irq_en: read/write.
  - bit 2 clear-sticky and bit 3 flush: write-1 self-clearing, read as 0.
- Other addresses: reads return 0, writes are ignored.

Engine FSM (all `m_*` strobes are combinational from state):
- IDLE: all `m_*` = 0. Go to LOAD when enable=1, TX FIFO not empty and RX FIFO not full. A full RX FIFO stalls the engine, so RX never overflows.
- LOAD: `m_CS=1`, `m_WEN=1`, `m_Addr=0x000`, `m_DataIn={24'b0, tx_head}`. Go to START.
- START: `m_WEN` write to 0x008 with data 1. Pop the TX FIFO. Clear the watchdog. Go to WAIT.
- WAIT: `m_REN=1` to 0x004, held every cycle.
  - If `m_DataOut[1]`=1, go to READ.
  - Else if the watchdog reaches TIMEOUT, set TMO and go to IDLE with no RX write.
- READ: `m_REN=1` to 0x000. Push `m_DataOut[7:0]` into RX. Go to IDLE.

`irq` = irq_en & ((tx_empty & ~busy) | TXOVF | TMO), registered.

Boundary rules:
- Push and engine pop in the same cycle: tx_count is unchanged.
- A push on full is dropped even if an engine pop occurs in the same cycle.
- CPU pop and READ push in the same cycle: rx_count is unchanged. A push on full cannot occur.
- Flush clears both FIFOs' pointers and counts immediately. An in-flight byte still completes, and its RX byte is stored after the flush.
- Clearing enable mid-transfer only blocks the next IDLE→LOAD; the current byte finishes.
- FIFO pointers wrap modulo DEPTH. The counts are `log2(DEPTH)+1` bits wide, zero-extended to 8.

## Timing
- Reset values: state IDLE; FIFOs empty; CTRL=0; sticky flags 0; `irq`=0; all `m_*`=0; `DataOut`=0.
- The TX write becomes visible in STATUS on the next cycle. The first LOAD starts at the earliest 1 cycle after the push.
- Per-byte overhead outside the SPI transfer: LOAD + START + READ + IDLE = 4 cycles, plus WAIT polling.
- The SPI `tx_done` pulse is 1 cycle wide. WAIT samples it every cycle and never misses it.
- An RX byte is readable the cycle after READ.
- `irq` lags its condition by 1 cycle.

## Structure
- Package `spi_stream_pkg`:
  - Register offsets (0x00/0x04/0x08) for both the CPU map and the SPI peripheral map.
  - STATUS and CTRL bit indices.
  - The 3-bit engine state enum (IDLE, LOAD, START, WAIT, READ).
- Sub-module `byte_fifo`, parameterised by DEPTH and 8 bits wide, with push/pop/flush, full/empty/count and a registered head. It is instantiated twice, once for TX and once for RX.

## Test plan
- Loopback model (MISO=MOSI): enable, push 0xA5, 0x3C → RX pops return 0xA5 then 0x3C; STATUS tx_empty=1, busy=0.
- Push DEPTH+1 bytes with enable=0 → tx_count=DEPTH, TXOVF=1. Write CTRL bit 2 → TXOVF=0.
- Fill RX to DEPTH with TX still non-empty → engine stays in IDLE. Pop one byte → exactly one more transfer occurs.
- SPI model that never raises `tx_done`, TIMEOUT=50 → TMO=1 after 50 WAIT cycles, no RX entry, `irq`=1 when irq_en=1.
- Assert `rst` during WAIT → all outputs return to reset values asynchronously and FIFOs are empty. After release, a new push transfers normally.
